// File: rtl/mask_lane_sequencer.sv
// Four-lane mask dispatch/reorder controller: round-robin issue with per-lane credits,
// per-lane in-order mask FIFOs, frame sequencing and 12-row band flagging.
module mask_lane_sequencer #(
  parameter int unsigned DATA_WIDTH      = 24,
  parameter int unsigned IMG_WIDTH       = 640,
  parameter int unsigned IMG_HEIGHT      = 480,
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter int unsigned TH_WIDTH        = 8
) (
  input  logic                  i_CLK,
  input  logic                  i_RST,
  input  logic                  i_START,
  input  logic [TH_WIDTH-1:0]   i_THRESHOLD,
  input  logic [DATA_WIDTH-1:0] i_DATA,
  input  logic                  i_DATA_VALID,
  output logic                  o_READY,
  output logic [DATA_WIDTH-1:0] o_LANE_DATA,
  output logic [3:0]            o_LANE_VALID,
  output logic [TH_WIDTH-1:0]   o_LANE_THRESHOLD,
  input  logic [3:0]            i_LANE_MASK,
  input  logic [3:0]            i_LANE_MASK_VALID,
  output logic                  o_MASK,
  output logic                  o_MASK_VALID,
  output logic                  o_FULL12_ROW,
  output logic                  o_BUSY,
  output logic                  o_DONE,
  output logic                  o_PROTO_ERR
);

  localparam int unsigned CW   = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned PW   = $clog2(MAX_OUTSTANDING);
  localparam int unsigned NPIX = IMG_WIDTH * IMG_HEIGHT;
  localparam int unsigned XW   = $clog2(NPIX + 1);
  localparam int unsigned COLW = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;

  localparam logic [CW-1:0]   CNT_MAX  = CW'(MAX_OUTSTANDING);
  localparam logic [XW-1:0]   PIX_LAST = XW'(NPIX - 1);
  localparam logic [COLW-1:0] COL_LAST = COLW'(IMG_WIDTH - 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  logic [1:0]                 state;
  logic [1:0]                 wr_lane;
  logic [1:0]                 rd_lane;
  logic [XW-1:0]              pix_cnt;
  logic [COLW-1:0]            col_cnt;
  logic [3:0]                 row_cnt;
  logic [CW-1:0]              cnt  [4];
  logic [MAX_OUTSTANDING-1:0] mem  [4];
  logic [PW:0]                wptr [4];
  logic [PW:0]                rptr [4];

  logic [3:0] fifo_empty;
  logic [3:0] fifo_full;
  logic [3:0] push;
  logic [3:0] issue;
  logic [3:0] pop_lane;
  logic [3:0] orphan;
  logic       accept;
  logic       pop;
  logic       start;
  logic       all_idle;

  always_comb begin
    start    = (state == ST_IDLE) && i_START;
    o_READY  = (state == ST_RUN) && (cnt[wr_lane] < CNT_MAX);
    accept   = o_READY && i_DATA_VALID;
    o_BUSY   = (state != ST_IDLE);
    o_DONE   = (state == ST_DONE);
    all_idle = 1'b1;
    for (int k = 0; k < 4; k++) begin
      fifo_empty[k] = (wptr[k] == rptr[k]);
      fifo_full[k]  = (wptr[k][PW] != rptr[k][PW]) &&
                      (wptr[k][PW-1:0] == rptr[k][PW-1:0]);
      issue[k]      = accept && (wr_lane == 2'(k));
      // IDLE drops stale returns silently; otherwise a return with no credit is an error.
      orphan[k]     = i_LANE_MASK_VALID[k] && (state != ST_IDLE) && (cnt[k] == '0);
      push[k]       = i_LANE_MASK_VALID[k] && (state != ST_IDLE) && (cnt[k] != '0) &&
                      !fifo_full[k];
      if ((cnt[k] != '0) || !fifo_empty[k]) begin
        all_idle = 1'b0;
      end
    end
    pop = !fifo_empty[rd_lane];
    for (int k = 0; k < 4; k++) begin
      pop_lane[k] = pop && (rd_lane == 2'(k));
    end
  end

  always_ff @(posedge i_CLK) begin
    for (int k = 0; k < 4; k++) begin
      if (push[k]) begin
        mem[k][wptr[k][PW-1:0]] <= i_LANE_MASK[k];
      end
    end
  end

  always_ff @(posedge i_CLK or posedge i_RST) begin
    if (i_RST) begin
      state            <= ST_IDLE;
      wr_lane          <= '0;
      rd_lane          <= '0;
      pix_cnt          <= '0;
      col_cnt          <= '0;
      row_cnt          <= '0;
      o_LANE_DATA      <= '0;
      o_LANE_VALID     <= '0;
      o_LANE_THRESHOLD <= '0;
      o_MASK           <= 1'b0;
      o_MASK_VALID     <= 1'b0;
      o_FULL12_ROW     <= 1'b0;
      o_PROTO_ERR      <= 1'b0;
      for (int k = 0; k < 4; k++) begin
        cnt[k]  <= '0;
        wptr[k] <= '0;
        rptr[k] <= '0;
      end
    end else begin
      o_LANE_VALID <= issue;
      if (accept) begin
        o_LANE_DATA <= i_DATA;
        wr_lane     <= wr_lane + 2'd1;
        pix_cnt     <= pix_cnt + XW'(1);
      end

      o_MASK_VALID <= pop;
      o_FULL12_ROW <= pop && (col_cnt == COL_LAST) && (row_cnt == 4'd11);
      if (pop) begin
        o_MASK  <= mem[rd_lane][rptr[rd_lane][PW-1:0]];
        rd_lane <= rd_lane + 2'd1;
        if (col_cnt == COL_LAST) begin
          col_cnt <= '0;
          row_cnt <= (row_cnt == 4'd11) ? 4'd0 : row_cnt + 4'd1;
        end else begin
          col_cnt <= col_cnt + COLW'(1);
        end
      end

      if (|orphan) begin
        o_PROTO_ERR <= 1'b1;
      end

      // Credits return at pop; a same-cycle issue and pop on one lane cancel out.
      for (int k = 0; k < 4; k++) begin
        if (push[k]) begin
          wptr[k] <= wptr[k] + 1'b1;
        end
        if (pop_lane[k]) begin
          rptr[k] <= rptr[k] + 1'b1;
        end
        if (issue[k] && !pop_lane[k]) begin
          cnt[k] <= cnt[k] + 1'b1;
        end else if (!issue[k] && pop_lane[k]) begin
          cnt[k] <= cnt[k] - 1'b1;
        end
      end

      case (state)
        ST_IDLE:  if (start) state <= ST_RUN;
        ST_RUN:   if (accept && (pix_cnt == PIX_LAST)) state <= ST_DRAIN;
        ST_DRAIN: if (all_idle) state <= ST_DONE;
        default:  state <= ST_IDLE;
      endcase

      if (start) begin
        o_LANE_THRESHOLD <= i_THRESHOLD;
        wr_lane          <= '0;
        rd_lane          <= '0;
        pix_cnt          <= '0;
        col_cnt          <= '0;
        row_cnt          <= '0;
        for (int k = 0; k < 4; k++) begin
          cnt[k]  <= '0;
          wptr[k] <= '0;
          rptr[k] <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_mask_lane_sequencer.sv
// Randomized bench for mask_lane_sequencer: behavioural lanes with fixed latency, an
// in-order mask scoreboard, a credit model for o_READY and a frame-phase model.
module tb_mask_lane_sequencer;
  localparam int W    = 4;
  localparam int H    = 24;
  localparam int NPIX = W * H;
  localparam int MO   = 4;
  localparam int BAND = W * 12;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_start = 1'b0;
  logic [7:0]  i_threshold = '0;
  logic [23:0] i_data = '0;
  logic        i_data_valid = 1'b0;
  logic        o_ready;
  logic [23:0] o_lane_data;
  logic [3:0]  o_lane_valid;
  logic [7:0]  o_lane_threshold;
  logic [3:0]  i_lane_mask = '0;
  logic [3:0]  i_lane_mask_valid = '0;
  logic        o_mask;
  logic        o_mask_valid;
  logic        o_full12_row;
  logic        o_busy;
  logic        o_done;
  logic        o_proto_err;

  mask_lane_sequencer #(
    .DATA_WIDTH(24), .IMG_WIDTH(W), .IMG_HEIGHT(H), .MAX_OUTSTANDING(MO), .TH_WIDTH(8)
  ) dut (
    .i_CLK(clk), .i_RST(rst), .i_START(i_start), .i_THRESHOLD(i_threshold),
    .i_DATA(i_data), .i_DATA_VALID(i_data_valid), .o_READY(o_ready),
    .o_LANE_DATA(o_lane_data), .o_LANE_VALID(o_lane_valid),
    .o_LANE_THRESHOLD(o_lane_threshold), .i_LANE_MASK(i_lane_mask),
    .i_LANE_MASK_VALID(i_lane_mask_valid), .o_MASK(o_mask), .o_MASK_VALID(o_mask_valid),
    .o_FULL12_ROW(o_full12_row), .o_BUSY(o_busy), .o_DONE(o_done),
    .o_PROTO_ERR(o_proto_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Model state: phase 0 idle, 1 run, 2 drain, 3 done.
  int   cyc = 0;
  int   phase = 0;
  int   n_acc, n_mask, n_done;
  int   th_m = 0;
  int   drv_th = 0;
  int   start_th = 0;
  bit   proto_m = 0;
  int   issued [4];
  int   emitted [4];
  bit   exp_q [$];
  bit   acc_prev = 0, start_prev = 0, inj_prev = 0, drained_prev = 0;
  logic [23:0] acc_data;
  int   lat [4];
  int   l_due [4][16];
  bit   l_msk [4][16];
  int   l_head [4];
  int   l_tail [4];
  bit   want_start = 0;
  int   vpct = 0;
  bit   inj_req = 0;

  task automatic reset_checks();
    check("rst_ready", 32'(o_ready), 32'(0));
    check("rst_lane_valid", 32'(o_lane_valid), 32'(0));
    check("rst_lane_data", 32'(o_lane_data), 32'(0));
    check("rst_thresh", 32'(o_lane_threshold), 32'(0));
    check("rst_mask", 32'(o_mask), 32'(0));
    check("rst_mask_valid", 32'(o_mask_valid), 32'(0));
    check("rst_full12", 32'(o_full12_row), 32'(0));
    check("rst_busy", 32'(o_busy), 32'(0));
    check("rst_done", 32'(o_done), 32'(0));
    check("rst_proto", 32'(o_proto_err), 32'(0));
  endtask

  task automatic tick();
    int         old;
    logic [3:0] mv;
    logic [3:0] mm;
    @(posedge clk);
    #1;
    cyc++;
    old = phase;
    if (acc_prev) begin
      issued[n_acc % 4]++;
      n_acc++;
      exp_q.push_back(acc_data[0]);
    end
    // n-th accepted pixel goes to lane n mod 4, one cycle later.
    check("lane_valid", 32'(o_lane_valid), acc_prev ? (32'(1) << ((n_acc - 1) % 4)) : 32'(0));
    if (acc_prev) check("lane_data", 32'(o_lane_data), 32'(acc_data));
    if (inj_prev) proto_m = 1;
    for (int k = 0; k < 4; k++) begin
      if (o_lane_valid[k]) begin
        l_due[k][l_tail[k] % 16] = cyc + lat[k];
        l_msk[k][l_tail[k] % 16] = o_lane_data[0];
        l_tail[k]++;
      end
    end
    if (o_mask_valid) begin
      check("mask_extra", 32'(exp_q.size() > 0), 32'(1));
      if (exp_q.size() > 0) check("mask", 32'(o_mask), 32'(exp_q.pop_front()));
      emitted[n_mask % 4]++;
      n_mask++;
    end
    check("band", 32'(o_full12_row), 32'(o_mask_valid && (n_mask % BAND == 0)));
    if (old == 0 && start_prev) begin
      phase = 1;
      th_m  = start_th;
    end else if (old == 1 && acc_prev && n_acc == NPIX) begin
      phase = 2;
    end else if (old == 2 && drained_prev) begin
      phase = 3;
    end else if (old == 3) begin
      phase = 0;
    end
    check("ready", 32'(o_ready),
          32'(phase == 1 && (issued[n_acc % 4] - emitted[n_acc % 4] < MO)));
    check("busy", 32'(o_busy), 32'(phase != 0));
    check("done", 32'(o_done), 32'(phase == 3));
    if (o_done) n_done++;
    check("thresh", 32'(o_lane_threshold), 32'(th_m));
    check("proto", 32'(o_proto_err), 32'(proto_m));
    drained_prev = (phase == 2) && (n_mask == NPIX);

    // Drive inputs for the cycle now in progress.
    start_prev   = want_start && (phase == 0);
    i_start      = want_start;
    i_threshold  = 8'(drv_th);
    start_th     = drv_th;
    i_data       = 24'($urandom);
    i_data_valid = ($urandom_range(99) < vpct);
    acc_prev     = i_data_valid && o_ready;
    acc_data     = i_data;
    mv = '0;
    mm = '0;
    for (int k = 0; k < 4; k++) begin
      if (l_head[k] != l_tail[k] && l_due[k][l_head[k] % 16] <= cyc) begin
        mv[k] = 1'b1;
        mm[k] = l_msk[k][l_head[k] % 16];
        l_head[k]++;
      end
    end
    inj_prev = 0;
    if (inj_req && phase == 1 && !mv[2] && issued[2] == emitted[2]) begin
      mv[2]    = 1'b1;
      mm[2]    = 1'($urandom);
      inj_req  = 0;
      inj_prev = 1;
    end
    i_lane_mask_valid = mv;
    i_lane_mask       = mm;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    reset_checks();
    phase = 0; proto_m = 0; th_m = 0;
    acc_prev = 0; start_prev = 0; inj_prev = 0; drained_prev = 0; inj_req = 0;
    exp_q.delete();
    issued = '{default: 0};
    emitted = '{default: 0};
    n_acc = 0; n_mask = 0;
    i_data_valid = 1'b0;
    i_start = 1'b0;
    want_start = 0;
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
  endtask

  task automatic run_frame(input int th, input int la, input int lb, input int lc,
                           input int ld, input int vp, input bit inj, input bit mid,
                           input int abort_at);
    int budget;
    bit mid_done;
    lat = '{la, lb, lc, ld};
    vpct = vp;
    issued = '{default: 0};
    emitted = '{default: 0};
    n_acc = 0; n_mask = 0; n_done = 0;
    exp_q.delete();
    inj_req = inj;
    drv_th = th;
    want_start = 1;
    tick();
    want_start = 0;
    budget = 0;
    mid_done = 0;
    do begin
      if (mid && !mid_done && n_acc >= 20) begin
        want_start = 1;
        drv_th = 99;
        mid_done = 1;
      end else begin
        want_start = 0;
        drv_th = th;
      end
      tick();
      budget++;
      if (abort_at > 0 && n_acc >= abort_at) begin
        do_reset();
        return;
      end
    end while ((phase != 0 || n_done == 0) && budget < 2000);
    check("frame_timeout", 32'(budget < 2000), 32'(1));
    check("mask_count", 32'(n_mask), 32'(NPIX));
    check("acc_count", 32'(n_acc), 32'(NPIX));
    check("done_count", 32'(n_done), 32'(1));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

  initial begin
    l_head = '{default: 0};
    l_tail = '{default: 0};
    lat = '{default: 1};
    issued = '{default: 0};
    emitted = '{default: 0};
    n_acc = 0; n_mask = 0; n_done = 0;
    repeat (3) @(posedge clk);
    #1;
    reset_checks();
    rst = 1'b0;
    vpct = 50;
    repeat (3) tick();

    // Full-rate frame with a stray start mid-run.
    run_frame(50, 1, 1, 1, 1, 100, 0, 1, 0);
    check("thresh_kept", 32'(o_lane_threshold), 32'(50));
    // Slow lane 1.
    run_frame(int'($urandom_range(255)), 1, 9, 1, 1, 100, 0, 0, 0);
    // Lane 3 returns ahead of lane 0, plus an uncredited return on lane 2.
    run_frame(int'($urandom_range(255)), 6, 2, 2, 1, 70, 1, 0, 0);
    check("proto_sticky", 32'(o_proto_err), 32'(1));
    // Mid-frame reset after 30 pixels, then stale returns while idle.
    run_frame(int'($urandom_range(255)), int'($urandom_range(1, 8)),
              int'($urandom_range(1, 8)), int'($urandom_range(1, 8)),
              int'($urandom_range(1, 8)), 90, 0, 0, 30);
    vpct = 50;
    repeat (20) tick();
    run_frame(int'($urandom_range(255)), int'($urandom_range(1, 12)),
              int'($urandom_range(1, 12)), int'($urandom_range(1, 12)),
              int'($urandom_range(1, 12)), 80, 0, 0, 0);
    run_frame(int'($urandom_range(255)), int'($urandom_range(1, 16)),
              int'($urandom_range(1, 16)), int'($urandom_range(1, 16)),
              int'($urandom_range(1, 16)), 60, 0, 0, 0);
    repeat (3) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
